regfile_arbiter: RTL and testbench

Shares the 8x8 register file (one write port, one registered read port) between N_REQ requesters. Write and read ports are arbitrated independently, each round-robin, with one grant per port per cycle. The block enforces read-after-write ordering on same-cycle address collisions and returns read data with a per-requester valid strobe. It sits between requester blocks and the register file; the register file's clrn is driven by the same system reset.

---
 rtl/regfile_arb_pkg.sv | 6 +
 rtl/regfile_arbiter_rr.sv | 42 ++++
 rtl/regfile_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared defaults for the register-file arbiter slice.
package regfile_arb_pkg;
    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 3;
    localparam int N_REQ_MAX = 4;
endpackage

// File: rtl/regfile_arbiter_rr.sv
// Round-robin arbiter: first eligible requester at or after the pointer wins;
// pointer moves past the winner only when the caller lets the grant stand.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_nxt;
    logic [N-1:0]  w_elig;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_elig  = req & ~mask;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % N]) begin
                w_found                       = 1'b1;
                w_win                         = PW'((int'(r_ptr) + k) % N);
                gnt[(int'(r_ptr) + k) % N]    = 1'b1;
            end
        end
        w_nxt = (int'(w_win) == N - 1) ? '0 : w_win + PW'(1);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_ptr <= '0;
        else if (advance && w_found)
            r_ptr <= w_nxt;
    end
endmodule

// File: rtl/regfile_arbiter.sv
// Shares one write port and one registered read port of an 8x8 register file
// between N_REQ requesters, keeping read-after-write order on address collisions.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [N_REQ-1:0]    req_wr,
    input  logic [N_REQ*AW-1:0] wr_addr,
    input  logic [N_REQ*DW-1:0] wr_data,
    input  logic [N_REQ-1:0]    req_rd,
    input  logic [N_REQ*AW-1:0] rd_addr,
    output logic [N_REQ-1:0]    gnt_wr,
    output logic [N_REQ-1:0]    gnt_rd,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                rf_wen,
    output logic [AW-1:0]       rf_wsel,
    output logic [DW-1:0]       rf_d,
    output logic [AW-1:0]       rf_rsel,
    input  logic [DW-1:0]       rf_q
);
    logic [N_REQ-1:0] w_wr_mask;
    logic [N_REQ-1:0] w_rd_cand;
    logic [AW-1:0]    w_wsel;
    logic [DW-1:0]    w_wd;
    logic [AW-1:0]    w_rd_addr;
    logic             w_collide;

    logic             r_rd_prio;
    logic [AW-1:0]    r_pend_addr;
    logic [N_REQ-1:0] r_rvalid_p1;

    // A held read outranks writes that target the address it is waiting on.
    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < N_REQ; i++)
            w_wr_mask[i] = r_rd_prio && (wr_addr[i*AW +: AW] == r_pend_addr);
    end

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk     (clk),
        .clrn    (clrn),
        .req     (req_wr),
        .mask    (w_wr_mask),
        .advance (1'b1),
        .gnt     (gnt_wr)
    );

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk     (clk),
        .clrn    (clrn),
        .req     (req_rd),
        .mask    ({N_REQ{1'b0}}),
        .advance (~w_collide),
        .gnt     (w_rd_cand)
    );

    always_comb begin
        w_wsel    = '0;
        w_wd      = '0;
        w_rd_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_wr[i]) begin
                w_wsel = wr_addr[i*AW +: AW];
                w_wd   = wr_data[i*DW +: DW];
            end
            if (w_rd_cand[i])
                w_rd_addr = rd_addr[i*AW +: AW];
        end
    end

    // Read of the address being written this cycle waits one cycle for the new data.
    assign w_collide = (|gnt_wr) && (|w_rd_cand) && (w_rd_addr == w_wsel);

    assign gnt_rd  = w_collide ? '0 : w_rd_cand;
    assign rf_rsel = w_collide ? '0 : w_rd_addr;
    assign rf_wen  = |gnt_wr;
    assign rf_wsel = w_wsel;
    assign rf_d    = w_wd;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rd_prio   <= 1'b0;
            r_pend_addr <= '0;
        end else if (w_collide) begin
            r_rd_prio   <= 1'b1;
            r_pend_addr <= w_rd_addr;
        end else if (r_rd_prio && (|gnt_rd) && (w_rd_addr == r_pend_addr)) begin
            r_rd_prio   <= 1'b0;
        end
    end

    // Read return stage: register file output lands one edge after the grant.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r_rvalid_p1 <= '0;
        else
            r_rvalid_p1 <= gnt_rd & req_rd;
    end

    assign rvalid = r_rvalid_p1;
    assign rdata  = rf_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x8 register file.
module tb_regfile_arbiter;
    localparam int N_REQ = 2;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic                clk;
    logic                clrn;
    logic [N_REQ-1:0]    req_wr;
    logic [N_REQ*AW-1:0] wr_addr;
    logic [N_REQ*DW-1:0] wr_data;
    logic [N_REQ-1:0]    req_rd;
    logic [N_REQ*AW-1:0] rd_addr;
    logic [N_REQ-1:0]    gnt_wr;
    logic [N_REQ-1:0]    gnt_rd;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                rf_wen;
    logic [AW-1:0]       rf_wsel;
    logic [DW-1:0]       rf_d;
    logic [AW-1:0]       rf_rsel;
    logic [DW-1:0]       rf_q;

    int n_cmp;
    int n_fail;

    regfile_arbiter #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .req_wr  (req_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .req_rd  (req_rd),
        .rd_addr (rd_addr),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rf_wen  (rf_wen),
        .rf_wsel (rf_wsel),
        .rf_d    (rf_d),
        .rf_rsel (rf_rsel),
        .rf_q    (rf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: write at the edge, registered read of the pre-edge contents.
    logic [DW-1:0] mem [8];
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < 8; k++) mem[k] <= '0;
        end else if (rf_wen) begin
            mem[rf_wsel] <= rf_d;
        end
    end
    always @(posedge clk) rf_q <= mem[rf_rsel];

    task automatic idle();
        req_wr  = '0;
        wr_addr = '0;
        wr_data = '0;
        req_rd  = '0;
        rd_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (gnt_wr !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_wr got %b exp 00", gnt_wr); end
        n_cmp++; if (gnt_rd !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_rd got %b exp 00", gnt_rd); end
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b exp 00", rvalid); end
        n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen got %b exp 0", rf_wen); end
        n_cmp++; if ({rf_wsel, rf_d, rf_rsel} !== 14'h0) begin n_fail++; $display("FAIL reset_rf_sel got %h/%h/%h exp 0", rf_wsel, rf_d, rf_rsel); end
    endtask

    task automatic test_wr_round_robin();
        logic [1:0] exp_g [4];
        logic [2:0] exp_s [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_s = '{3'd2, 3'd5, 3'd2, 3'd5};
        req_wr  = 2'b11;
        wr_addr = {3'd5, 3'd2};
        wr_data = {8'h55, 8'h22};
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (gnt_wr !== exp_g[c]) begin n_fail++; $display("FAIL rr_gnt_wr[%0d] got %b exp %b", c, gnt_wr, exp_g[c]); end
            n_cmp++; if (rf_wsel !== exp_s[c]) begin n_fail++; $display("FAIL rr_wsel[%0d] got %0d exp %0d", c, rf_wsel, exp_s[c]); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_raw_next_cycle();
        req_wr  = 2'b01;
        wr_addr = {3'd0, 3'd3};
        wr_data = {8'h00, 8'hA5};
        #1;
        n_cmp++; if (gnt_wr !== 2'b01) begin n_fail++; $display("FAIL raw_gnt_wr got %b exp 01", gnt_wr); end
        n_cmp++; if ({rf_wen, rf_wsel, rf_d} !== {1'b1, 3'd3, 8'hA5}) begin n_fail++; $display("FAIL raw_wport got %b/%0d/%h exp 1/3/a5", rf_wen, rf_wsel, rf_d); end
        @(negedge clk);
        idle();
        req_rd  = 2'b10;
        rd_addr = {3'd3, 3'd0};
        #1;
        n_cmp++; if (gnt_rd !== 2'b10) begin n_fail++; $display("FAIL raw_gnt_rd got %b exp 10", gnt_rd); end
        n_cmp++; if (rf_rsel !== 3'd3) begin n_fail++; $display("FAIL raw_rsel got %0d exp 3", rf_rsel); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL raw_rvalid got %b exp 10", rvalid); end
        n_cmp++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL raw_rdata got %h exp a5", rdata); end
        @(negedge clk);
    endtask

    task automatic test_collision();
        req_wr  = 2'b01;
        wr_addr = {3'd0, 3'd4};
        wr_data = {8'h00, 8'h3C};
        req_rd  = 2'b10;
        rd_addr = {3'd4, 3'd0};
        #1;
        n_cmp++; if (gnt_wr !== 2'b01) begin n_fail++; $display("FAIL col_gnt_wr got %b exp 01", gnt_wr); end
        n_cmp++; if (gnt_rd !== 2'b00) begin n_fail++; $display("FAIL col_gnt_rd_held got %b exp 00", gnt_rd); end
        @(negedge clk);
        wr_data = {8'h00, 8'hFF};
        #1;
        n_cmp++; if (gnt_wr !== 2'b00) begin n_fail++; $display("FAIL col_wr_masked got %b exp 00", gnt_wr); end
        n_cmp++; if (gnt_rd !== 2'b10) begin n_fail++; $display("FAIL col_gnt_rd got %b exp 10", gnt_rd); end
        @(negedge clk);
        req_rd = 2'b00;
        #1;
        n_cmp++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL col_rvalid got %b exp 10", rvalid); end
        n_cmp++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL col_rdata got %h exp 3c", rdata); end
        n_cmp++; if (gnt_wr !== 2'b01) begin n_fail++; $display("FAIL col_wr_resume got %b exp 01", gnt_wr); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_no_starvation();
        req_wr  = 2'b01;
        wr_addr = {3'd0, 3'd1};
        wr_data = {8'h00, 8'h11};
        req_rd  = 2'b10;
        rd_addr = {3'd1, 3'd0};
        #1;
        n_cmp++; if ({gnt_wr, gnt_rd} !== 4'b0100) begin n_fail++; $display("FAIL stv_cycle0 got wr=%b rd=%b exp wr=01 rd=00", gnt_wr, gnt_rd); end
        @(negedge clk);
        wr_data = {8'h00, 8'h22};
        #1;
        n_cmp++; if ({gnt_wr, gnt_rd} !== 4'b0010) begin n_fail++; $display("FAIL stv_cycle1 got wr=%b rd=%b exp wr=00 rd=10", gnt_wr, gnt_rd); end
        @(negedge clk);
        req_rd = 2'b00;
        #1;
        n_cmp++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL stv_rvalid got %b exp 10", rvalid); end
        n_cmp++; if (rdata !== 8'h11) begin n_fail++; $display("FAIL stv_rdata got %h exp 11", rdata); end
        n_cmp++; if (gnt_wr !== 2'b01) begin n_fail++; $display("FAIL stv_wr_resume got %b exp 01", gnt_wr); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        req_rd  = 2'b11;
        rd_addr = {3'd1, 3'd3};
        req_wr  = 2'b10;
        wr_addr = {3'd2, 3'd0};
        wr_data = {8'h5A, 8'h00};
        #1;
        n_cmp++; if (gnt_rd !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt_rd0 got %b exp 01", gnt_rd); end
        n_cmp++; if ({gnt_wr, rf_wsel, rf_d} !== {2'b10, 3'd2, 8'h5A}) begin n_fail++; $display("FAIL b2b_wport got %b/%0d/%h exp 10/2/5a", gnt_wr, rf_wsel, rf_d); end
        @(negedge clk);
        req_wr = 2'b00;
        req_rd = 2'b10;
        #1;
        n_cmp++; if (gnt_rd !== 2'b10) begin n_fail++; $display("FAIL b2b_gnt_rd1 got %b exp 10", gnt_rd); end
        n_cmp++; if ({rvalid, rdata} !== {2'b01, 8'hA5}) begin n_fail++; $display("FAIL b2b_ret0 got %b/%h exp 01/a5", rvalid, rdata); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if ({rvalid, rdata} !== {2'b10, 8'h22}) begin n_fail++; $display("FAIL b2b_ret1 got %b/%h exp 10/22", rvalid, rdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rvalid_idle got %b exp 00", rvalid); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req_rd  = 2'b01;
        rd_addr = {3'd0, 3'd3};
        req_wr  = 2'b01;
        wr_addr = {3'd0, 3'd6};
        wr_data = {8'h00, 8'h77};
        #1;
        n_cmp++; if ({gnt_wr, gnt_rd} !== 4'b0101) begin n_fail++; $display("FAIL rst_pre_gnt got wr=%b rd=%b exp 01/01", gnt_wr, gnt_rd); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if ({rvalid, rdata} !== {2'b01, 8'hA5}) begin n_fail++; $display("FAIL rst_pre_ret got %b/%h exp 01/a5", rvalid, rdata); end
        clrn = 1'b0;
        #1;
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid_drop got %b exp 00", rvalid); end
        @(negedge clk);
        clrn = 1'b1;
        req_wr  = 2'b11;
        wr_addr = {3'd7, 3'd0};
        wr_data = {8'h99, 8'h88};
        req_rd  = 2'b11;
        rd_addr = {3'd5, 3'd3};
        #1;
        n_cmp++; if (gnt_wr !== 2'b01) begin n_fail++; $display("FAIL rst_wp_cleared got %b exp 01", gnt_wr); end
        n_cmp++; if (gnt_rd !== 2'b01) begin n_fail++; $display("FAIL rst_rp_cleared got %b exp 01", gnt_rd); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if ({rvalid, rdata} !== {2'b01, 8'h00}) begin n_fail++; $display("FAIL rst_rf_cleared got %b/%h exp 01/00", rvalid, rdata); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle();
        clrn = 1'b0;
        test_reset();
        test_wr_round_robin();
        test_raw_next_cycle();
        test_collision();
        test_no_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
